// File: rtl/rv32i_defs.sv
// RV32I constants and opcode-class helpers shared by the decode stage.
// Opcode classification lives here so every consumer agrees on the format table.
package rv32i_defs;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   function automatic imm_fmt_e imm_format(input logic [6:0] opc);
      imm_fmt_e fmt;
      case (opc)
         OPC_OPIMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
         OPC_STORE:                     fmt = IMM_S;
         OPC_BRANCH:                    fmt = IMM_B;
         OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
         OPC_JAL:                       fmt = IMM_J;
         default:                       fmt = IMM_NONE;
      endcase
      return fmt;
   endfunction

   function automatic logic uses_rs1(input logic [6:0] opc);
      return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
   endfunction

   // Branches and stores carry immediate bits in the rd field, so rd is forced to 0.
   function automatic logic has_rd(input logic [6:0] opc);
      return !((opc == OPC_BRANCH) || (opc == OPC_STORE));
   endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate generator: instruction word in, sign-extended immediate out.
module imm_gen #(
   parameter int XLEN = rv32i_defs::XLEN
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm
);
   import rv32i_defs::*;

   imm_fmt_e    w_fmt;
   logic [31:0] w_imm32;

   assign w_fmt = imm_format(i_instr[6:0]);

   always_comb begin
      w_imm32 = '0;
      case (w_fmt)
         IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode/operand-fetch stage: EX/WB operand bypass, load-use stall detection
// and the ID/EX pipeline register, fed from fetch over a valid/ready handshake.
module id_stage #(
   parameter int XLEN   = rv32i_defs::XLEN,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   output logic [4:0]      rf_rs1,
   output logic [4:0]      rf_rs2,
   input  logic [XLEN-1:0] rf_rv1,
   input  logic [XLEN-1:0] rf_rv2,
   input  logic            ex_valid,
   input  logic            ex_we,
   input  logic            ex_is_load,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_result,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_op1,
   output logic [XLEN-1:0] id_op2,
   output logic [XLEN-1:0] id_imm,
   output logic [4:0]      id_rd
);
   import rv32i_defs::*;

   logic [6:0]      w_opc;
   logic [4:0]      w_rs [2];
   logic [XLEN-1:0] w_rv [2];
   logic [XLEN-1:0] w_op [2];
   logic            w_uses_rs1;
   logic            w_uses_rs2;
   logic            w_stall;
   logic            w_advance;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm;

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_op1;
   logic [XLEN-1:0] r_op2;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_rd;

   assign w_opc      = if_instr[6:0];
   assign w_rs[0]    = if_instr[19:15];
   assign w_rs[1]    = if_instr[24:20];
   assign w_rv[0]    = rf_rv1;
   assign w_rv[1]    = rf_rv2;
   assign rf_rs1     = w_rs[0];
   assign rf_rs2     = w_rs[1];
   assign w_uses_rs1 = uses_rs1(w_opc);
   assign w_uses_rs2 = uses_rs2(w_opc);
   assign w_rd       = has_rd(w_opc) ? if_instr[11:7] : 5'd0;

   // A load in EX has no data yet; hold the consumer one cycle so WB can bypass it.
   assign w_stall = ex_valid & ex_is_load & ex_we & (ex_rd != 5'd0) &
                    (((ex_rd == w_rs[0]) & w_uses_rs1) |
                     ((ex_rd == w_rs[1]) & w_uses_rs2));

   assign w_advance = ~r_valid | id_ready;
   assign if_ready  = w_advance & ~w_stall & ~flush;

   // WB must be bypassed too: the rf write lands on the same edge, after our read.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         w_op[k] = w_rv[k];
         if (w_rs[k] == 5'd0)
            w_op[k] = '0;
         else if (FWD_EN && ex_valid && ex_we && !ex_is_load && (ex_rd == w_rs[k]))
            w_op[k] = ex_result;
         else if (FWD_EN && wb_we && (wb_rd == w_rs[k]))
            w_op[k] = wb_data;
      end
   end

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .i_instr (if_instr),
      .o_imm   (w_imm)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
         r_op1   <= '0;
         r_op2   <= '0;
         r_imm   <= '0;
         r_rd    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_advance) begin
         if (w_stall) begin
            r_valid <= 1'b0;
         end else begin
            r_valid <= if_valid;
            r_pc    <= if_pc;
            r_instr <= if_instr;
            r_op1   <= w_op[0];
            r_op2   <= w_op[1];
            r_imm   <= w_imm;
            r_rd    <= w_rd;
         end
      end
   end

   assign id_valid = r_valid;
   assign id_pc    = r_pc;
   assign id_instr = r_instr;
   assign id_op1   = r_op1;
   assign id_op2   = r_op2;
   assign id_imm   = r_imm;
   assign id_rd    = r_rd;

endmodule
